// File: rtl/ext_mem_model_pkg.sv
// Shared types and helpers for the multi-channel external memory model.
package ext_mem_model_pkg;

  // Largest supported latency; sets the width of the per-channel counter.
  localparam int MAX_LAT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } chan_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Number of bytes moved by an access of the given size in bits.
  function automatic int size_to_nbytes(input int size);
    return size / 8;
  endfunction

endpackage

// File: rtl/ext_mem_chan_ctrl.sv
// Per-channel request classification, latency sequencing and sticky error flags.
//
// state | meaning
// IDLE  | no transfer in flight; a valid request starts one this cycle (cnt 0)
// BUSY  | transfer in flight; cnt_q is the index of the current cycle
module ext_mem_chan_ctrl
  import ext_mem_model_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 7,
  parameter int SIZE_W    = 5,
  parameter int MEMSIZE   = 64,
  parameter int BASE_ADDR = 32,
  parameter int RD_LAT    = 2,
  parameter int WR_LAT    = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              oe_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [SIZE_W-1:0] size_i,
  output logic              done_o,
  output logic              first_o,
  output logic              rd_o,
  output logic              bad_o,
  output logic              err_conflict_o,
  output logic              err_range_o,
  output logic              err_size_o
);

  localparam int CW = clog2(MAX_LAT);

  chan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_rd_q, op_rd_d;
  logic          in_range, req, conflict, size_ok, range_bad;
  logic          done, first;
  int            lat;

  // Classify the current request: address window, size legality and overrun.
  always_comb begin
    int a, s;
    a         = int'(addr_i);
    s         = int'(size_i);
    in_range  = (a >= BASE_ADDR) && (a < BASE_ADDR + MEMSIZE);
    conflict  = in_range && oe_i && we_i;
    req       = in_range && (oe_i ^ we_i);
    size_ok   = (s >= 8) && (s <= DATA_W) && ((s % 8) == 0);
    range_bad = size_ok && ((a - BASE_ADDR) + size_to_nbytes(s) > MEMSIZE);
  end

  // Next-state and completion logic; a type switch mid-transfer counts as a drop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_rd_d = op_rd_q;
    done    = 1'b0;
    first   = 1'b0;
    lat     = oe_i ? RD_LAT : WR_LAT;
    case (state_q)
      IDLE: begin
        if (req) begin
          first = 1'b1;
          if (lat == 1) begin
            done = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CW'(1);
            op_rd_d = oe_i;
          end
        end
      end
      BUSY: begin
        lat = op_rd_q ? RD_LAT : WR_LAT;
        if (req && (oe_i == op_rd_q)) begin
          if (int'(cnt_q) == lat - 1) begin
            done    = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign done_o  = done & ~rst_i;
  assign first_o = first & ~rst_i;
  assign rd_o    = (state_q == IDLE) ? oe_i : op_rd_q;
  assign bad_o   = ~size_ok | range_bad;

  // State register and sticky error flags, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      op_rd_q        <= 1'b0;
      err_conflict_o <= 1'b0;
      err_range_o    <= 1'b0;
      err_size_o     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_rd_q <= op_rd_d;
      if (conflict) err_conflict_o <= 1'b1;
      if (req && range_bad) err_range_o <= 1'b1;
      if (req && !size_ok) err_size_o <= 1'b1;
    end
  end

endmodule

// File: rtl/ext_mem_model_mc.sv
// Multi-channel external memory slave: byte array, write priority and read muxing.
module ext_mem_model_mc
  import ext_mem_model_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 7,
  parameter int SIZE_W    = 5,
  parameter int MEMSIZE   = 64,
  parameter int BASE_ADDR = 32,
  parameter int RD_LAT    = 2,
  parameter int WR_LAT    = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          Mout_oe_ram,
  input  logic [N_CH-1:0]          Mout_we_ram,
  input  logic [N_CH*ADDR_W-1:0]   Mout_addr_ram,
  input  logic [N_CH*DATA_W-1:0]   Mout_Wdata_ram,
  input  logic [N_CH*SIZE_W-1:0]   Mout_data_ram_size,
  input  logic                     init_we,
  input  logic [clog2(MEMSIZE)-1:0] init_addr,
  input  logic [7:0]               init_data,
  output logic [N_CH*DATA_W-1:0]   M_Rdata_ram,
  output logic [N_CH-1:0]          M_DataRdy,
  output logic [N_CH-1:0]          err_conflict,
  output logic [N_CH-1:0]          err_range,
  output logic [N_CH-1:0]          err_size
);

  localparam int AW = clog2(MEMSIZE);
  localparam int NB = DATA_W / 8;

  logic [7:0]                   mem_q [MEMSIZE];
  logic [N_CH-1:0]              done, first, rd, bad, commit;
  logic [N_CH-1:0][DATA_W-1:0]  live, hold_q;
  int                           off_c [N_CH];
  int                           nb_c  [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ext_mem_chan_ctrl #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .SIZE_W   (SIZE_W),
      .MEMSIZE  (MEMSIZE),
      .BASE_ADDR(BASE_ADDR),
      .RD_LAT   (RD_LAT),
      .WR_LAT   (WR_LAT)
    ) u_ctrl (
      .clk_i         (clock),
      .rst_i         (reset),
      .oe_i          (Mout_oe_ram[g]),
      .we_i          (Mout_we_ram[g]),
      .addr_i        (Mout_addr_ram[g*ADDR_W +: ADDR_W]),
      .size_i        (Mout_data_ram_size[g*SIZE_W +: SIZE_W]),
      .done_o        (done[g]),
      .first_o       (first[g]),
      .rd_o          (rd[g]),
      .bad_o         (bad[g]),
      .err_conflict_o(err_conflict[g]),
      .err_range_o   (err_range[g]),
      .err_size_o    (err_size[g])
    );
  end

  assign commit = done & ~rd & ~bad;

  // Gather the addressed bytes per channel; bytes past the size and bad accesses read as 0.
  always_comb begin
    live = '0;
    for (int c = 0; c < N_CH; c++) begin
      off_c[c] = int'(Mout_addr_ram[c*ADDR_W +: ADDR_W]) - BASE_ADDR;
      nb_c[c]  = size_to_nbytes(int'(Mout_data_ram_size[c*SIZE_W +: SIZE_W]));
      for (int b = 0; b < NB; b++) begin
        int idx;
        idx = off_c[c] + b;
        if (!bad[c] && (b < nb_c[c]) && (idx >= 0) && (idx < MEMSIZE))
          live[c][b*8 +: 8] = mem_q[idx[AW-1:0]];
      end
    end
  end

  // Capture read bytes on the first request cycle for delivery at completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++)
        if (first[c] && rd[c]) hold_q[c] <= live[c];
    end
  end

  // Drive read data only while a read completes so slaves can be OR-combined.
  always_comb begin
    M_Rdata_ram = '0;
    M_DataRdy   = done;
    for (int c = 0; c < N_CH; c++)
      if (done[c] && rd[c])
        M_Rdata_ram[c*DATA_W +: DATA_W] = first[c] ? live[c] : hold_q[c];
  end

  // Byte array update: preload first, then channels in ascending order so the highest index wins.
  always_ff @(posedge clock) begin
    if (init_we && (int'(init_addr) < MEMSIZE))
      mem_q[init_addr] <= init_data;
    if (!reset) begin
      for (int c = 0; c < N_CH; c++) begin
        if (commit[c]) begin
          for (int b = 0; b < NB; b++) begin
            int idx;
            idx = off_c[c] + b;
            if ((b < nb_c[c]) && (idx >= 0) && (idx < MEMSIZE))
              mem_q[idx[AW-1:0]] <= Mout_Wdata_ram[c*DATA_W + b*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ext_mem_model_mc.sv
// Directed bench for ext_mem_model_mc; a second instance runs with RD_LAT=3.
module tb_ext_mem_model_mc;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  oe, we;
  logic [13:0] addr;
  logic [31:0] wdata;
  logic [9:0]  size;
  logic        init_we;
  logic [5:0]  init_addr;
  logic [7:0]  init_data;

  logic [31:0] rdata_a, rdata_b;
  logic [1:0]  rdy_a, rdy_b, ecf_a, ecf_b, erg_a, erg_b, esz_a, esz_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ext_mem_model_mc dut_a (
    .clock(clock), .reset(reset),
    .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
    .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .M_Rdata_ram(rdata_a), .M_DataRdy(rdy_a),
    .err_conflict(ecf_a), .err_range(erg_a), .err_size(esz_a)
  );

  ext_mem_model_mc #(.RD_LAT(3)) dut_b (
    .clock(clock), .reset(reset),
    .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
    .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .M_Rdata_ram(rdata_b), .M_DataRdy(rdy_b),
    .err_conflict(ecf_b), .err_range(erg_b), .err_size(esz_b)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int ch, input logic o, input logic w, input logic [6:0] a,
                       input logic [15:0] wd, input logic [4:0] sz);
    oe[ch]             = o;
    we[ch]             = w;
    addr[ch*7 +: 7]    = a;
    wdata[ch*16 +: 16] = wd;
    size[ch*5 +: 5]    = sz;
  endtask

  task automatic idle_all;
    oe = '0; we = '0; addr = '0; wdata = '0; size = '0; init_we = 1'b0;
  endtask

  initial begin
    logic [7:0] pre [5];
    logic [5:0] rv_a, rv_b;
    logic       got;
    pre = '{8'hAB, 8'hCD, 8'h00, 8'h5A, 8'h00};
    idle_all();
    init_addr = '0; init_data = '0;
    reset = 1'b1;
    tick(); tick();

    chk("reset_rdy", {30'd0, rdy_a}, 32'd0);
    chk("reset_rdata", rdata_a, 32'd0);
    chk("reset_flags", {26'd0, ecf_a, erg_a, esz_a}, 32'd0);
    reset = 1'b0;

    // preload 0x20..0x24
    for (int i = 0; i < 5; i++) begin
      init_we = 1'b1; init_addr = 6'(i); init_data = pre[i];
      tick();
    end
    init_we = 1'b0;

    // ch0 read 0x20 size 16, RD_LAT=2
    drive(0, 1, 0, 7'h20, 16'h0, 5'd16);
    #1;
    chk("rd_c1_rdy", {30'd0, rdy_a}, 32'd0);
    chk("rd_c1_data", rdata_a, 32'd0);
    tick();
    chk("rd_c2_rdy", {30'd0, rdy_a}, 32'd1);
    chk("rd_c2_data", rdata_a, 32'h0000CDAB);
    idle_all();
    #1;
    chk("rd_after_data", rdata_a, 32'd0);
    tick();

    // ch1 partial write 0x22 size 8
    drive(1, 0, 1, 7'h22, 16'h1234, 5'd8);
    #1;
    chk("wr_rdy", {30'd0, rdy_a}, 32'd2);
    chk("wr_rdata", rdata_a, 32'd0);
    tick();
    idle_all();
    tick();
    drive(0, 1, 0, 7'h22, 16'h0, 5'd16);
    tick();
    chk("partial_readback", rdata_a, 32'h00005A34);
    idle_all();
    tick();

    // three-way collision on 0x24
    drive(0, 0, 1, 7'h24, 16'h0011, 5'd8);
    drive(1, 0, 1, 7'h24, 16'h0022, 5'd8);
    init_we = 1'b1; init_addr = 6'd4; init_data = 8'h33;
    #1;
    chk("coll_rdy", {30'd0, rdy_a}, 32'd3);
    tick();
    idle_all();
    tick();
    drive(0, 1, 0, 7'h24, 16'h0, 5'd8);
    tick();
    chk("coll_readback", rdata_a, 32'h00000022);
    idle_all();
    tick();

    // read-before-write on 0x20
    drive(0, 1, 0, 7'h20, 16'h0, 5'd8);
    drive(1, 0, 1, 7'h20, 16'h0077, 5'd8);
    #1;
    chk("rbw_c1_rdy", {30'd0, rdy_a}, 32'd2);
    tick();
    drive(1, 0, 0, 7'h0, 16'h0, 5'd0);
    #1;
    chk("rbw_c2_rdy", {30'd0, rdy_a}, 32'd1);
    chk("rbw_old_data", rdata_a, 32'h000000AB);
    idle_all();
    tick();
    drive(0, 1, 0, 7'h20, 16'h0, 5'd8);
    tick();
    chk("rbw_new_data", rdata_a, 32'h00000077);
    idle_all();
    tick();

    // out-of-range read: bench waits a bounded number of cycles, none expected
    drive(0, 1, 0, 7'h10, 16'h0, 5'd16);
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rdy_a[0]) got = 1'b1;
      if (rdata_a != 32'd0) got = 1'b1;
      tick();
    end
    chk("oor_no_rdy", {31'd0, got}, 32'd0);
    chk("oor_flags", {26'd0, ecf_a, erg_a, esz_a}, 32'd0);
    idle_all();
    tick();

    // conflict on ch0
    drive(0, 1, 1, 7'h20, 16'h0, 5'd8);
    #1;
    chk("cf_no_rdy_c1", {30'd0, rdy_a}, 32'd0);
    tick(); tick();
    chk("cf_no_rdy_c3", {30'd0, rdy_a}, 32'd0);
    chk("cf_flag", {30'd0, ecf_a}, 32'd1);
    idle_all();
    tick();
    chk("cf_sticky", {30'd0, ecf_a}, 32'd1);

    // range overrun on ch1
    drive(1, 1, 0, 7'h5F, 16'h0, 5'd16);
    tick();
    chk("rng_rdy", {30'd0, rdy_a}, 32'd2);
    chk("rng_rdata", rdata_a, 32'd0);
    chk("rng_flag", {30'd0, erg_a}, 32'd2);
    idle_all();
    tick();

    // illegal size 12 on ch1
    drive(1, 1, 0, 7'h20, 16'h0, 5'd12);
    tick();
    chk("sz_rdy", {30'd0, rdy_a}, 32'd2);
    chk("sz_rdata", rdata_a, 32'd0);
    chk("sz_flag", {30'd0, esz_a}, 32'd2);
    chk("flags_all", {26'd0, ecf_a, erg_a, esz_a}, 32'b01_10_10);
    idle_all();
    tick();

    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("flags_cleared", {26'd0, ecf_a, erg_a, esz_a}, 32'd0);

    // RD_LAT=3: reset at cnt=1 aborts the read
    drive(0, 1, 0, 7'h21, 16'h0, 5'd8);
    tick();
    reset = 1'b1;
    #1;
    chk("b_rst_rdy", {30'd0, rdy_b}, 32'd0);
    chk("b_rst_rdata", rdata_b, 32'd0);
    chk("a_rst_rdy", {30'd0, rdy_a}, 32'd0);
    tick();
    chk("b_rst_rdy2", {30'd0, rdy_b}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("b_restart_c1", {30'd0, rdy_b}, 32'd0);
    tick();
    chk("b_restart_c2", {30'd0, rdy_b}, 32'd0);
    tick();
    chk("b_restart_c3", {30'd0, rdy_b}, 32'd1);
    chk("b_mem_intact", rdata_b, 32'h000000CD);
    idle_all();
    tick();

    // back-to-back held read for 6 cycles
    drive(0, 1, 0, 7'h21, 16'h0, 5'd8);
    rv_a = '0; rv_b = '0;
    #1;
    for (int i = 0; i < 6; i++) begin
      rv_a[i] = rdy_a[0];
      rv_b[i] = rdy_b[0];
      tick();
    end
    chk("b2b_lat3", {26'd0, rv_b}, 32'b100100);
    chk("b2b_lat2", {26'd0, rv_a}, 32'b101010);
    idle_all();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_mem_model_mc.md
Name: ext_mem_model_mc

Overview:
- Parametrised, multi-channel external-memory slave model for Bambu-generated accelerators.
- Serves N_CH master channels (Mout_oe/we/addr/Wdata/data_ram_size) from a byte array mapped at BASE_ADDR.
- Supports configurable read and write latency, multi-byte little-endian accesses and byte-masked partial writes.
- Adds what the earlier single-byte model lacked: a preload port, deterministic write-collision resolution and sticky error flags. Used in testbenches and FPGA-side emulation.

Parameters:
- N_CH, 2, number of master channels.
- DATA_W, 16, data bits per channel; a multiple of 8.
- ADDR_W, 7, address bits per channel.
- SIZE_W, 5, width of the size field per channel; equals clog2(DATA_W)+1.
- MEMSIZE, 64, bytes of backing storage.
- BASE_ADDR, 32, first byte address served.
- RD_LAT, 2, read latency in cycles; at least 1.
- WR_LAT, 1, write latency in cycles; at least 1.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- Mout_oe_ram  in  N_CH  per-channel read request.
- Mout_we_ram  in  N_CH  per-channel write request.
- Mout_addr_ram  in  N_CH*ADDR_W  byte address; channel i in slice i.
- Mout_Wdata_ram  in  N_CH*DATA_W  write data, little-endian.
- Mout_data_ram_size  in  N_CH*SIZE_W  access size in bits.
- init_we  in  1  preload byte strobe.
- init_addr  in  clog2(MEMSIZE)  preload byte offset from BASE_ADDR.
- init_data  in  8  preload byte.
- M_Rdata_ram  out  N_CH*DATA_W  read data; zero when not valid, so it can be OR-combined with other slaves.
- M_DataRdy  out  N_CH  per-channel completion pulse.
- err_conflict  out  N_CH  sticky: oe and we asserted together.
- err_range  out  N_CH  sticky: access straddles the end of the memory.
- err_size  out  N_CH  sticky: size is not in {8, 16, ..., DATA_W}.

Behaviour:
- Reset: all outputs 0, channel counters 0, pending writes discarded. Memory contents are not cleared.
- Reset mid-transaction aborts it; no DataRdy pulse, no write commit.
- In range: addr >= BASE_ADDR and addr < BASE_ADDR+MEMSIZE. An out-of-range channel is ignored: no DataRdy, Rdata 0, no error flag.
- Access bytes: nb = size/8, covering addr..addr+nb-1.
- If the last byte is at or beyond BASE_ADDR+MEMSIZE: err_range is set, the write is suppressed, read data is 0, and DataRdy still pulses after the latency (the master must not hang).
- Bad size (sets err_size): the access is handled the same way as an err_range access.
- Per-channel FSM (ext_mem_chan_ctrl):
  - IDLE: on a valid request, go to BUSY with cnt=0.
  - BUSY: cnt increments each cycle while the request is held. DataRdy=1 when cnt==LAT-1, with LAT=RD_LAT for reads and WR_LAT for writes. Return to IDLE the next cycle.
  - If the request is dropped before completion, return to IDLE with no side effect.
- Request still asserted the cycle after DataRdy: a new transaction starts (back-to-back throughput of one transfer per LAT cycles).
- oe & we together on a channel: err_conflict[i] is set, the request is ignored and the channel stays IDLE.
- Read data:
  - Bytes are sampled on the first request cycle (cnt==0) and held for delivery.
  - They are driven on M_Rdata_ram slice i only during the DataRdy cycle.
  - Upper bits beyond size are 0.
  - RD_LAT=1 gives a combinational read in the same cycle.
- Write: bytes are committed at the rising edge ending the DataRdy cycle, using Wdata[nb*8-1:0]; other bytes are unchanged.
- Same-byte writes from several channels in one edge: the highest channel index wins.
- Read sampling versus a write committing on the same edge: the read returns the old data (read-before-write).
- Preload: init_we writes one byte per cycle. If it hits the same byte as a channel write on the same edge, the channel write wins. init_addr >= MEMSIZE is ignored.
- Error flags are sticky until reset and have no effect on other channels.

Decomposition:
- Package ext_mem_model_pkg holds:
  - clog2 function;
  - byte-count function size_to_nbytes(size);
  - channel state enum {IDLE, BUSY};
  - constant MAX_LAT=16 for the counter width.
- Sub-module ext_mem_chan_ctrl, one instance per channel, holds the latency counter, FSM, request classification (range/size/conflict) and sticky flags.
- The top level holds the byte array, collision priority and read muxing.

Test Plan:
- Preload: 0x20=0xAB, 0x21=0xCD. Ch0 read addr 0x20, size 16, held -> DataRdy[0]=1 exactly one cycle after request start, Rdata[15:0]=0xCDAB, zero in other cycles.
- Partial write: ch1 write 0x22, Wdata 0x1234, size 8 -> DataRdy[1] in the first cycle; a later read of 0x22 size 16 returns 0x??34 with the upper byte unchanged from before.
- Collision: ch0 writes 0x11 and ch1 writes 0x22 to 0x24 in the same cycle; init_we writes 0x33 to the same byte on the same edge -> readback 0x22.
- Errors:
  - ch0 oe=we=1 -> err_conflict[0]=1, no DataRdy, remains 1 until reset.
  - ch1 read 0x5F size 16 -> err_range[1]=1, DataRdy pulse, Rdata 0.
  - size 12 -> err_size=1.
- Out of range: read of 0x10 -> no DataRdy, Rdata 0, all error flags 0. The bench must time out, not hang the DUT.
- Variant RD_LAT=3:
  - reset asserted at cnt=1 -> no DataRdy, outputs 0, memory intact.
  - back-to-back reads held for 6 cycles -> DataRdy in cycles 3 and 6.
